// File: rtl/prog_mem.sv
// Program memory with a run-mode registered read port and a streaming load port.
// Handshake: a load word transfers on a rising edge where ld_valid && ld_ready and neither ld_abort nor ld_start is high.
module prog_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [ADDR_W-1:0] adr,
  output logic [DATA_W-1:0] dout,
  input  logic              ld_start,
  input  logic              ld_abort,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy,
  output logic [DATA_W-1:0] ld_sum,
  output logic              state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr, wptr_nxt;
  logic [DATA_W-1:0] sum_nxt;
  logic              done_nxt;
  logic              we;
  logic [DATA_W-1:0] mem [DEPTH];

  assign busy      = (state == LOAD);
  assign ld_ready  = (state == LOAD);
  assign state_dbg = (state == LOAD);

  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    sum_nxt   = ld_sum;
    done_nxt  = 1'b0;
    we        = 1'b0;
    case (state)
      RUN: begin
        // Abort alongside start keeps the block in RUN.
        if (ld_start && !ld_abort) begin
          state_nxt = LOAD;
          wptr_nxt  = '0;
          sum_nxt   = '0;
        end
      end
      LOAD: begin
        if (ld_abort) begin
          state_nxt = RUN;
        end else if (ld_start) begin
          wptr_nxt = '0;
          sum_nxt  = '0;
        end else if (ld_valid) begin
          we       = 1'b1;
          wptr_nxt = wptr + ADDR_W'(1);
          sum_nxt  = ld_sum + ld_data;
          if (wptr == ADDR_W'(DEPTH - 1)) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= RUN;
      wptr    <= '0;
      ld_sum  <= '0;
      ld_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      wptr    <= wptr_nxt;
      ld_sum  <= sum_nxt;
      ld_done <= done_nxt;
    end
  end

  // Memory is flop-based so reset can clear every word at once.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      dout <= '0;
    end else if (state == LOAD) begin
      dout <= '0;
    end else begin
      dout <= mem[adr];
    end
  end

endmodule
